multichannel_sequencer: RTL and testbench
=========================================

// Module: multichannel_sequencer
// PURPOSE
//  Parametrised, multi-channel successor to the fixed test-structure sequencer.
//  Up to N_CH timed outputs, each with its own programmable rise and fall times.
//  Also provides a static select bus, burst repetition, abort and a status word.
//  Sits between the Raspberry Pi SPI command word (spi16 dout/write) and the test-structure DIO pins.
//  Runs are started by the external pulse-generator trigger.
// PARAMETERS
//  N_CH    4   number of timed channels (1..12)
//  TIME_W  10  width of time counter and all time registers (1..12), unit = 1 clk
//  SEL_W   4   width of static select output (1..12)
// PORTS
//  clk           in   1       system clock (PLL c0)
//  res_n         in   1       asynchronous active-low reset (PLL locked)
//  cmd_write     in   1       1-cycle strobe: cmd_word valid
//  cmd_word      in   16      command CCCC_DDDDDDDDDDDD (C = code, D = 12-bit data)
//  trigger       in   1       asynchronous run trigger; rising edge starts a run
//  ch_out        out  N_CH    timed channel outputs (registered)
//  static_out    out  SEL_W   static select value, updated at run start
//  ready_flag    out  1       1 = IDLE, a trigger will be accepted
//  measure_flag  out  1       1 = RUN and t >= meas_start
//  status_word   out  16      {state[1:0], cmd_en, 1'b0, repeats_left[11:0]}
// BEHAVIOUR
//  Reset
//   - state = IDLE; cmd_en = 0; all config registers = 0.
//   - ch_out = 0, static_out = 0; ready_flag = 1, measure_flag = 0.
//   - Reset asserted mid-run: immediate return to these values, with no completion of the run.
//  Commands (acted on only in the cycle where cmd_write = 1)
//   - 1001 ENA: cmd_en <= D[0]. Always accepted.
//   - All other codes are ignored while cmd_en = 0.
//   - 0000 SEL_VALUE: shadow_sel <= D[SEL_W-1:0].
//   - 0001 CH_PTR: ptr <= D. Value >= N_CH makes the following 0010/0011 commands no-ops.
//   - 0010 ON_TIME: on[ptr] <= D[TIME_W-1:0].
//   - 0011 OFF_TIME: off[ptr] <= D[TIME_W-1:0].
//   - 0100 END_TIME: end_t <= D[TIME_W-1:0].
//   - 0101 IDLE_LVL: idle <= D[N_CH-1:0].
//   - 0110 REPEAT: repeat_n <= D (0 = single run).
//   - 1000 MEAS_START: meas_start <= D[TIME_W-1:0].
//   - 0111 ABORT: if in RUN, state <= IDLE next edge and outputs return to idle levels.
//   - Undefined codes: no effect.
//   - Upper D bits beyond the target register width are dropped.
//  Config writes during RUN update the shadow registers only.
//   - The active copy is snapshotted at run start; a write never alters a run in progress.
//  Trigger path
//   - 2-FF synchroniser, then rising-edge detect.
//   - Trigger sampled high at edge k: state <= RUN with t = 0 at edge k+2.
//  FSM
//   - IDLE -> RUN on trigger edge with end_t != 0.
//     - Snapshot on/off/end/meas/idle/repeat; static_out <= shadow_sel.
//     - repeats_left <= repeat_n.
//     - end_t == 0: trigger ignored.
//   - RUN: t increments by 1 each clk.
//     - At t == end_t-1, if repeats_left != 0: t <= 0 and repeats_left decrements (no gap cycle).
//     - Otherwise: state <= IDLE.
//   - A trigger edge while in RUN is ignored; edges are not queued.
//  Outputs
//   - ch_out[i] <= idle[i] ^ (RUN & t >= on[i] & t < off[i]), registered one clk after t.
//   - First visible switch of channel i is at edge k+3+on[i].
//   - on >= off: channel never leaves its idle level.
//   - off > end_t: pulse is truncated at the end of the run.
//   - On return to IDLE, ch_out = idle and static_out holds its value.
//   - measure_flag has the same 1-clk registration as ch_out.
//   - ready_flag = (state == IDLE), combinational from state.
//   - status_word state encoding: 00 = IDLE, 01 = RUN.
// TESTING
//  1. No ENA, write ON_TIME 5 -> register stays 0. ENA D=1, repeat -> on[0] = 5.
//  2. ch0 on=3 off=7, end=10, trigger high at edge k.
//     -> ch_out[0] high from edge k+6 to k+10.
//     -> ready_flag low from k+2; ready_flag high at edge k+12.
//  3. idle = 4'b0010, ch1 on=2 off=2 -> ch_out[1] stays 1 through the whole run.
//  4. repeat = 2, end = 4 -> 3 back-to-back pulse trains, 12 RUN cycles; extra trigger mid-run ignored.
//  5. ABORT at t = 5, or res_n low at t = 5 -> ch_out = idle (reset: 0) and ready_flag = 1 immediately.
//  6. SEL_VALUE 9 written during RUN -> static_out unchanged until the next trigger, then 4'd9.

Source files
------------

// File: rtl/multichannel_sequencer.sv
// Multi-channel trigger-started pulse sequencer driven by 16-bit SPI command words.
// Shadow configuration is copied into an active set at each run start.
module multichannel_sequencer #(
    parameter int N_CH   = 4,
    parameter int TIME_W = 10,
    parameter int SEL_W  = 4
) (
    input  logic             clk,
    input  logic             res_n,
    input  logic             cmd_write,
    input  logic [15:0]      cmd_word,
    input  logic             trigger,
    output logic [N_CH-1:0]  ch_out,
    output logic [SEL_W-1:0] static_out,
    output logic             ready_flag,
    output logic             measure_flag,
    output logic [15:0]      status_word
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01
    } state_t;

    localparam logic [3:0] C_SEL   = 4'h0;
    localparam logic [3:0] C_PTR   = 4'h1;
    localparam logic [3:0] C_ON    = 4'h2;
    localparam logic [3:0] C_OFF   = 4'h3;
    localparam logic [3:0] C_END   = 4'h4;
    localparam logic [3:0] C_IDLE  = 4'h5;
    localparam logic [3:0] C_REP   = 4'h6;
    localparam logic [3:0] C_ABORT = 4'h7;
    localparam logic [3:0] C_MEAS  = 4'h8;
    localparam logic [3:0] C_ENA   = 4'h9;

    localparam logic [TIME_W-1:0] T_ONE = TIME_W'(1);

    state_t state_q, state_d;
    logic   cmd_en_q, cmd_en_d;
    logic [2:0] sync_q, sync_d;

    logic [SEL_W-1:0]  sel_sh_q, sel_sh_d;
    logic [11:0]       ptr_q, ptr_d;
    logic [TIME_W-1:0] on_sh_q [N_CH];
    logic [TIME_W-1:0] on_sh_d [N_CH];
    logic [TIME_W-1:0] off_sh_q [N_CH];
    logic [TIME_W-1:0] off_sh_d [N_CH];
    logic [TIME_W-1:0] end_sh_q, end_sh_d;
    logic [N_CH-1:0]   idle_sh_q, idle_sh_d;
    logic [11:0]       rep_sh_q, rep_sh_d;
    logic [TIME_W-1:0] meas_sh_q, meas_sh_d;

    logic [TIME_W-1:0] on_a_q [N_CH];
    logic [TIME_W-1:0] on_a_d [N_CH];
    logic [TIME_W-1:0] off_a_q [N_CH];
    logic [TIME_W-1:0] off_a_d [N_CH];
    logic [TIME_W-1:0] end_a_q, end_a_d;
    logic [N_CH-1:0]   idle_a_q, idle_a_d;
    logic [TIME_W-1:0] meas_a_q, meas_a_d;

    logic [TIME_W-1:0] t_q, t_d;
    logic [11:0]       rep_left_q, rep_left_d;
    logic [SEL_W-1:0]  static_q, static_d;
    logic [N_CH-1:0]   ch_q, ch_d;
    logic              meas_q, meas_d;

    logic [3:0]  code;
    logic [11:0] data;
    logic        wr_en, rise, start, abort;
    logic        run, run_live, t_last;
    logic [N_CH-1:0] win;

    assign code     = cmd_word[15:12];
    assign data     = cmd_word[11:0];
    assign wr_en    = cmd_write & cmd_en_q;
    assign sync_d   = {sync_q[1:0], trigger};
    assign rise     = sync_q[1] & ~sync_q[2];
    assign start    = ready_flag & rise & (end_sh_q != '0);
    assign abort    = run & wr_en & (code == C_ABORT);
    assign run_live = run & ~abort;
    assign t_last   = (t_q == end_a_q - T_ONE);

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN: begin
                if (abort || (t_last && rep_left_q == '0)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ready_flag = (state_q == ST_IDLE);
        run        = (state_q == ST_RUN);
    end

    // Command decode: ENA is always honoured, everything else needs cmd_en.
    always_comb begin
        cmd_en_d  = cmd_en_q;
        sel_sh_d  = sel_sh_q;
        ptr_d     = ptr_q;
        on_sh_d   = on_sh_q;
        off_sh_d  = off_sh_q;
        end_sh_d  = end_sh_q;
        idle_sh_d = idle_sh_q;
        rep_sh_d  = rep_sh_q;
        meas_sh_d = meas_sh_q;
        if (cmd_write && code == C_ENA) cmd_en_d = data[0];
        if (wr_en) begin
            unique case (1'b1)
                code == C_SEL:  sel_sh_d  = data[SEL_W-1:0];
                code == C_PTR:  ptr_d     = data;
                code == C_ON: begin
                    for (int i = 0; i < N_CH; i++) begin
                        if (ptr_q == 12'(i)) on_sh_d[i] = data[TIME_W-1:0];
                    end
                end
                code == C_OFF: begin
                    for (int i = 0; i < N_CH; i++) begin
                        if (ptr_q == 12'(i)) off_sh_d[i] = data[TIME_W-1:0];
                    end
                end
                code == C_END:  end_sh_d  = data[TIME_W-1:0];
                code == C_IDLE: idle_sh_d = data[N_CH-1:0];
                code == C_REP:  rep_sh_d  = data;
                code == C_MEAS: meas_sh_d = data[TIME_W-1:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        on_a_d     = on_a_q;
        off_a_d    = off_a_q;
        end_a_d    = end_a_q;
        idle_a_d   = idle_a_q;
        meas_a_d   = meas_a_q;
        static_d   = static_q;
        rep_left_d = rep_left_q;
        t_d        = '0;
        if (start) begin
            on_a_d     = on_sh_q;
            off_a_d    = off_sh_q;
            end_a_d    = end_sh_q;
            idle_a_d   = idle_sh_q;
            meas_a_d   = meas_sh_q;
            static_d   = sel_sh_q;
            rep_left_d = rep_sh_q;
        end
        if (run_live) begin
            if (!t_last) begin
                t_d = t_q + T_ONE;
            end else if (rep_left_q != '0) begin
                rep_left_d = rep_left_q - 12'd1;
            end
        end
        win = '0;
        for (int i = 0; i < N_CH; i++) begin
            win[i] = (t_q >= on_a_q[i]) && (t_q < off_a_q[i]);
        end
        // An abort forces idle levels on the same edge the FSM leaves RUN.
        ch_d   = idle_a_q ^ (win & {N_CH{run_live}});
        meas_d = run_live && (t_q >= meas_a_q);
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            cmd_en_q   <= 1'b0;
            sync_q     <= '0;
            sel_sh_q   <= '0;
            ptr_q      <= '0;
            on_sh_q    <= '{default: '0};
            off_sh_q   <= '{default: '0};
            end_sh_q   <= '0;
            idle_sh_q  <= '0;
            rep_sh_q   <= '0;
            meas_sh_q  <= '0;
            on_a_q     <= '{default: '0};
            off_a_q    <= '{default: '0};
            end_a_q    <= '0;
            idle_a_q   <= '0;
            meas_a_q   <= '0;
            t_q        <= '0;
            rep_left_q <= '0;
            static_q   <= '0;
            ch_q       <= '0;
            meas_q     <= 1'b0;
        end else begin
            cmd_en_q   <= cmd_en_d;
            sync_q     <= sync_d;
            sel_sh_q   <= sel_sh_d;
            ptr_q      <= ptr_d;
            on_sh_q    <= on_sh_d;
            off_sh_q   <= off_sh_d;
            end_sh_q   <= end_sh_d;
            idle_sh_q  <= idle_sh_d;
            rep_sh_q   <= rep_sh_d;
            meas_sh_q  <= meas_sh_d;
            on_a_q     <= on_a_d;
            off_a_q    <= off_a_d;
            end_a_q    <= end_a_d;
            idle_a_q   <= idle_a_d;
            meas_a_q   <= meas_a_d;
            t_q        <= t_d;
            rep_left_q <= rep_left_d;
            static_q   <= static_d;
            ch_q       <= ch_d;
            meas_q     <= meas_d;
        end
    end

    assign ch_out       = ch_q;
    assign static_out   = static_q;
    assign measure_flag = meas_q;
    assign status_word  = {state_q, cmd_en_q, 1'b0, rep_left_q};

endmodule

// File: tb/tb_multichannel_sequencer.sv
// Scoreboard bench: a per-edge reference model derives outputs from run start time,
// elapsed cycles and the snapshotted configuration; a monitor compares at negedge.
module tb_multichannel_sequencer;
    localparam int N_CH   = 4;
    localparam int TIME_W = 10;
    localparam int SEL_W  = 4;

    logic clk = 1'b0;
    logic res_n, cmd_write, trigger;
    logic [15:0] cmd_word;
    logic [N_CH-1:0] ch_out;
    logic [SEL_W-1:0] static_out;
    logic ready_flag, measure_flag;
    logic [15:0] status_word;

    multichannel_sequencer #(.N_CH(N_CH), .TIME_W(TIME_W), .SEL_W(SEL_W)) dut (
        .clk(clk), .res_n(res_n), .cmd_write(cmd_write), .cmd_word(cmd_word),
        .trigger(trigger), .ch_out(ch_out), .static_out(static_out),
        .ready_flag(ready_flag), .measure_flag(measure_flag),
        .status_word(status_word)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N_CH-1:0]  ch;
        logic [SEL_W-1:0] st;
        logic             rdy;
        logic             meas;
        logic [15:0]      stat;
    } obs_t;

    typedef struct {
        int   e;
        obs_t o;
    } exp_t;

    exp_t sbq[$];
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    bit trg = 0;

    always @(posedge clk) cyc++;

    // reference model state
    bit m_en, m_run, h1, h2, h3;
    int m_ptr, m_s, m_rl, m_static;
    int s_sel, s_end, s_idle, s_rep, s_meas;
    int s_on[N_CH];
    int s_off[N_CH];
    int a_end, a_idle, a_rep, a_meas;
    int a_on[N_CH];
    int a_off[N_CH];

    task automatic model_reset();
        m_en = 0; m_run = 0; h1 = 0; h2 = 0; h3 = 0;
        m_ptr = 0; m_s = 0; m_rl = 0; m_static = 0;
        s_sel = 0; s_end = 0; s_idle = 0; s_rep = 0; s_meas = 0;
        a_end = 0; a_idle = 0; a_rep = 0; a_meas = 0;
        for (int i = 0; i < N_CH; i++) begin
            s_on[i] = 0; s_off[i] = 0; a_on[i] = 0; a_off[i] = 0;
        end
    endtask

    always @(negedge clk) begin : monitor
        obs_t got;
        exp_t x;
        got = {ch_out, static_out, ready_flag, measure_flag, status_word};
        while (sbq.size() > 0 && sbq[0].e < cyc) begin
            x = sbq.pop_front();
            n_cmp++; n_bad++;
            $display("FAIL stale_entry edge=%0d now=%0d", x.e, cyc);
        end
        if (sbq.size() > 0 && sbq[0].e == cyc) begin
            x = sbq.pop_front();
            n_cmp++;
            if (got !== x.o) begin
                n_bad++;
                $display("FAIL edge%0d ch=%b/%b static=%h/%h rdy=%b/%b meas=%b/%b stat=%h/%h (got/exp)",
                         x.e, got.ch, x.o.ch, got.st, x.o.st, got.rdy, x.o.rdy,
                         got.meas, x.o.meas, got.stat, x.o.stat);
            end
        end
    end

    // Drive one cycle of stimulus and predict the outputs after the coming edge.
    task automatic step(input bit wr, input logic [15:0] w);
        exp_t x;
        bit was_run, abort, act, meas;
        int el, tc, code, d;
        logic [N_CH-1:0] ch;
        @(negedge clk);
        cmd_write = wr; cmd_word = w; trigger = trg;
        x.e = cyc + 1;
        was_run = m_run; el = 0; tc = 0;
        if (was_run) begin
            el = x.e - 1 - m_s;
            tc = el % a_end;
        end
        code = int'(w[15:12]);
        d    = int'(w[11:0]);
        act   = wr && m_en;
        abort = was_run && act && code == 7;
        ch = a_idle[N_CH-1:0];
        if (was_run && !abort) begin
            for (int i = 0; i < N_CH; i++) begin
                if (tc >= a_on[i] && tc < a_off[i]) ch[i] = ~ch[i];
            end
        end
        meas = was_run && !abort && tc >= a_meas;
        if (abort) begin
            m_run = 0; m_rl = a_rep - el / a_end;
        end else if (was_run && el == (a_rep + 1) * a_end - 1) begin
            m_run = 0; m_rl = 0;
        end else if (was_run) begin
            m_rl = a_rep - (el + 1) / a_end;
        end else if (h2 && !h3 && s_end != 0) begin
            m_run = 1; m_s = x.e;
            a_end = s_end; a_idle = s_idle; a_rep = s_rep; a_meas = s_meas;
            a_on = s_on; a_off = s_off;
            m_static = s_sel; m_rl = s_rep;
        end
        if (wr && code == 9) begin
            m_en = d[0];
        end else if (act) begin
            case (code)
                0: s_sel = d % (1 << SEL_W);
                1: m_ptr = d;
                2: if (m_ptr < N_CH) s_on[m_ptr] = d % (1 << TIME_W);
                3: if (m_ptr < N_CH) s_off[m_ptr] = d % (1 << TIME_W);
                4: s_end = d % (1 << TIME_W);
                5: s_idle = d % (1 << N_CH);
                6: s_rep = d;
                8: s_meas = d % (1 << TIME_W);
                default: ;
            endcase
        end
        h3 = h2; h2 = h1; h1 = trg;
        x.o = {ch, m_static[SEL_W-1:0], !m_run, meas,
               m_run ? 2'b01 : 2'b00, m_en, 1'b0, m_rl[11:0]};
        sbq.push_back(x);
    endtask

    task automatic cmd(input logic [3:0] c, input logic [11:0] d);
        step(1'b1, {c, d});
    endtask

    task automatic idle_n(input int n);
        repeat (n) step(1'b0, 16'h0000);
    endtask

    task automatic pulse(input int n);
        trg = 1; idle_n(n); trg = 0;
    endtask

    task automatic rand_cmd();
        int c, d;
        c = $urandom_range(0, 15);
        d = $urandom_range(0, 4095);
        if (c == 7 && $urandom_range(0, 2) != 0) c = 2;
        case (c)
            1: d = $urandom_range(0, 5);
            2, 3: d = $urandom_range(0, 25);
            4: d = $urandom_range(0, 23);
            6: d = $urandom_range(0, 3);
            8: d = $urandom_range(0, 22);
            9: d = ($urandom_range(0, 7) != 0) ? 1 : 0;
            default: ;
        endcase
        cmd(c[3:0], d[11:0]);
    endtask

    task automatic chk_reset(input string nm);
        obs_t got;
        obs_t want;
        got  = {ch_out, static_out, ready_flag, measure_flag, status_word};
        want = {{N_CH{1'b0}}, {SEL_W{1'b0}}, 1'b1, 1'b0, 16'h0000};
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, want);
        end
    endtask

    initial begin
        res_n = 1'b1; cmd_write = 1'b0; cmd_word = '0; trigger = 1'b0;
        model_reset();
        #2 res_n = 1'b0;
        #1 chk_reset("reset_initial");
        repeat (3) @(negedge clk);
        res_n = 1'b1;

        // commands before ENA are ignored, trigger with end_t==0 ignored
        cmd(4'h1, 12'd0); cmd(4'h2, 12'd5); cmd(4'h4, 12'd10); cmd(4'h7, 12'd0);
        pulse(2); idle_n(8);
        cmd(4'h9, 12'd1); cmd(4'h1, 12'd0); cmd(4'h2, 12'd5);
        cmd(4'h3, 12'd8); cmd(4'h4, 12'd6); pulse(1); idle_n(10);
        // on=3 off=7 end=10
        cmd(4'h2, 12'd3); cmd(4'h3, 12'd7); cmd(4'h4, 12'd10); pulse(1); idle_n(14);
        // idle level with on==off
        cmd(4'h5, 12'h002); cmd(4'h1, 12'd1); cmd(4'h2, 12'd2); cmd(4'h3, 12'd2);
        pulse(1); idle_n(14);
        // repeats, truncated pulse, measure, retrigger mid-run
        cmd(4'h1, 12'd2); cmd(4'h2, 12'd1); cmd(4'h3, 12'd20);
        cmd(4'h6, 12'd2); cmd(4'h4, 12'd4); cmd(4'h8, 12'd2);
        pulse(1); idle_n(5); pulse(1); idle_n(12);
        // abort at t=5
        cmd(4'h6, 12'd0); cmd(4'h4, 12'hC14); pulse(1); idle_n(7);
        cmd(4'h7, 12'd0); idle_n(4);
        // out-of-range pointer, undefined codes, upper data bits
        cmd(4'h1, 12'd7); cmd(4'h2, 12'd1); step(1'b1, 16'hA123); step(1'b1, 16'hF0FF);
        cmd(4'h5, 12'hFF5);
        // select write mid-run only appears at next start
        pulse(1); idle_n(4); cmd(4'h0, 12'd9); idle_n(25); pulse(1); idle_n(25);

        for (int it = 0; it < 60; it++) begin
            repeat ($urandom_range(1, 5)) rand_cmd();
            if ($urandom_range(0, 3) != 0) pulse($urandom_range(1, 3));
            repeat ($urandom_range(0, 40)) begin
                if ($urandom_range(0, 9) == 0) rand_cmd();
                else idle_n(1);
            end
        end

        // reset in the middle of a run
        cmd(4'h9, 12'd1); cmd(4'h4, 12'd20); cmd(4'h5, 12'h00F);
        pulse(1); idle_n(7);
        @(negedge clk);
        #1 res_n = 1'b0;
        #1 chk_reset("reset_mid_run");
        repeat (2) @(negedge clk);
        res_n = 1'b1;
        model_reset();
        idle_n(6);
        cmd(4'h9, 12'd1); cmd(4'h4, 12'd3); pulse(1); idle_n(8);

        for (int i = 0; i < 6 && sbq.size() > 0; i++) @(negedge clk);
        #1;
        if (sbq.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain left=%0d exp=0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
